cnn_layer_accel_wht_seq_gen: RTL and testbench
==============================================

# cnn_layer_accel_wht_seq_gen

Programmable weight-address sequencer for the CNN layer accelerator. It holds one weight-address sequence per phase, selected by a Gray-coded phase input. On each start it streams the selected sequence out over a valid/ready interface to the weight buffer read port. This is the parametrised successor of the fixed 4-phase, 5-entry weight sequence table: it adds run-time programmable tables and per-phase lengths, backpressure, and done signalling.

## Interface
- C_NUM_PHASES, 4, number of phases/tables; power of two, ≥2
- C_MAX_SEQ_LEN, 5, entries per phase table; ≥1
- C_WHT_ADDR_WIDTH, 4, width of emitted weight address
- Derived: PW = clog2(C_NUM_PHASES), IW = clog2(C_MAX_SEQ_LEN) (min 1), LW = clog2(C_MAX_SEQ_LEN+1)

Ports:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- cfg_wr_en  in  1  write cfg_data to table[cfg_phase][cfg_idx]
- cfg_len_wr_en  in  1  write cfg_len to len[cfg_phase]
- cfg_phase  in  PW  binary phase index for config writes
- cfg_idx  in  IW  entry index for config writes
- cfg_data  in  C_WHT_ADDR_WIDTH  table entry value
- cfg_len  in  LW  sequence length for cfg_phase
- cfg_err  out  1  one-cycle pulse: config write rejected
- start  in  1  start-sequence request
- gray_code  in  PW  Gray-coded phase select, sampled with start
- loop  in  1  repeat-mode request (see Configuration)
- stop  in  1  terminate loop at next sequence end
- busy  out  1  high from start acceptance until final beat accepted
- wht_data_valid  out  1  output beat valid
- wht_data_rdy  in  1  consumer ready
- wht_data_addr  out  C_WHT_ADDR_WIDTH  weight address
- wht_data_last  out  1  marks final entry of the current sequence pass
- seq_done  out  1  one-cycle pulse when the final beat is accepted

## Operation
- Storage: C_NUM_PHASES×C_MAX_SEQ_LEN register table and C_NUM_PHASES length registers. On reset, all entries are 0 and all lengths are 0.
- Config writes are accepted only when busy=0. A write with busy=1 is dropped and pulses cfg_err on the next cycle.
- A write with cfg_idx ≥ C_MAX_SEQ_LEN is dropped and pulses cfg_err.
- A cfg_len value > C_MAX_SEQ_LEN is stored clamped to C_MAX_SEQ_LEN.
- Phase decode: gray_code is converted to binary (b[i] = XOR of g[PW-1:i]), so 2'b00→0, 01→1, 11→2, 10→3.
- FSM states:
  - IDLE: start=1 latches the decoded phase and its length L, idx←0 → RUN. If L=0, go → DONE directly with no beats.
  - RUN: present table[phase][idx] with wht_data_valid=1. On valid&&rdy: if idx=L-1 → DONE, else idx+1.
  - DONE: seq_done=1 for one cycle, busy←0 → IDLE. In loop mode, go → RUN with idx←0 instead (busy stays 1).
- start is ignored outside IDLE. A start in the same cycle as the DONE→IDLE transition is ignored.
- wht_data_last = valid && idx=L-1.
- Output data and last are stable while valid && !rdy.

## Timing
- Reset values: wht_data_valid=0, wht_data_addr=0, wht_data_last=0, busy=0, seq_done=0, cfg_err=0, FSM=IDLE.
- Latency: with start at cycle T, busy=1 and the first valid beat appear at T+1 (registered read).
- Throughput: with rdy held high, one beat per cycle.
- seq_done asserts the cycle after the last beat is accepted. busy falls in that same cycle.
- A config write at cycle T is visible to a start at T+1.
- Asserting rst_n low mid-sequence clears outputs immediately (asynchronous). After reset the table is zero and must be reprogrammed.

## Configuration
- CNN_LAYER_ACCEL_WHT_SEQ_LOOP_EN:
  - Defined: when loop=1 at start, the sequence repeats indefinitely. seq_done pulses at the end of every pass, and wht_data_last asserts on every pass. stop=1 (sampled any cycle while busy) ends operation at the end of the current pass.
  - Not defined: loop and stop are ignored, and each start yields exactly one pass.

## Test plan
- Program phase0={1,3,4,5,6}, len 5; start with gray_code=00, rdy=1 → addrs 1,3,4,5,6 on T+1..T+5; last on 6; seq_done at T+6.
- Program phase2={4,5,6,2,3}, len 5; start with gray_code=11 → addrs 4,5,6,2,3 (Gray decode check). Also gray_code=10 selects phase3.
- Backpressure: rdy toggles 1,0,0,1… → each addr held unchanged while rdy=0; no beat lost or duplicated.
- Edge cases: len 0 → seq_done with no valid beats. cfg_len=7 with C_MAX_SEQ_LEN=5 → 5 beats. cfg_wr_en while busy → cfg_err pulse, table unchanged.
- LOOP_EN defined: phase1={7,8} len 2, loop=1 → 7,8,7,8…; stop mid-pass → ends after the next 8.
- Assert rst_n=0 during RUN → valid/busy=0 immediately; a restart returns addr 0 until reprogrammed.

Source files
------------

// File: rtl/cnn_layer_accel_wht_seq_gen.sv
`default_nettype none
// ============================================================================
// Module   : cnn_layer_accel_wht_seq_gen
// Purpose  : Per-phase programmable weight-address sequencer, valid/ready out.
//            Repeat mode enabled by defining CNN_LAYER_ACCEL_WHT_SEQ_LOOP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module cnn_layer_accel_wht_seq_gen #(
  parameter int C_NUM_PHASES     = 4,
  parameter int C_MAX_SEQ_LEN    = 5,
  parameter int C_WHT_ADDR_WIDTH = 4,
  localparam int PW = $clog2(C_NUM_PHASES),
  localparam int IW = (C_MAX_SEQ_LEN > 1) ? $clog2(C_MAX_SEQ_LEN) : 1,
  localparam int LW = $clog2(C_MAX_SEQ_LEN + 1)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        cfg_wr_en,
  input  logic                        cfg_len_wr_en,
  input  logic [PW-1:0]               cfg_phase,
  input  logic [IW-1:0]               cfg_idx,
  input  logic [C_WHT_ADDR_WIDTH-1:0] cfg_data,
  input  logic [LW-1:0]               cfg_len,
  output logic                        cfg_err,
  input  logic                        start,
  input  logic [PW-1:0]               gray_code,
  input  logic                        loop,
  input  logic                        stop,
  output logic                        busy,
  output logic                        wht_data_valid,
  input  logic                        wht_data_rdy,
  output logic [C_WHT_ADDR_WIDTH-1:0] wht_data_addr,
  output logic                        wht_data_last,
  output logic                        seq_done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                      state_q;
  logic [C_WHT_ADDR_WIDTH-1:0] tbl_q [C_NUM_PHASES][C_MAX_SEQ_LEN];
  logic [LW-1:0]               len_q [C_NUM_PHASES];
  logic [PW-1:0]               phase_q;
  logic [IW-1:0]               idx_q;
  logic [LW-1:0]               run_len_q;
  logic                        loop_q, stop_q, busy_q, valid_q, last_q, done_q, cfg_err_q;
  logic [C_WHT_ADDR_WIDTH-1:0] addr_q;

  logic [PW-1:0] phase_d;
  logic [LW-1:0] start_len_d;
  logic [IW-1:0] idx_d;
  logic [LW-1:0] cfg_len_d;
  logic          cfg_idx_ok_d;
  logic          cfg_err_d;
  logic          loop_req, stop_req;
  logic          repeat_d;

`ifdef CNN_LAYER_ACCEL_WHT_SEQ_LOOP_EN
  assign loop_req = loop;
  assign stop_req = stop;
`else
  logic unused_loop_stop;
  assign unused_loop_stop = loop ^ stop;
  assign loop_req = 1'b0;
  assign stop_req = 1'b0;
`endif

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    phase_d = '0;
    for (int i = 0; i < PW; i++) begin
      phase_d[i] = ^(gray_code >> i);
    end
  end

  assign start_len_d  = len_q[phase_d];
  assign idx_d        = idx_q + IW'(1);
  assign cfg_idx_ok_d = (32'(cfg_idx) < C_MAX_SEQ_LEN);
  assign cfg_len_d    = (cfg_len > LW'(C_MAX_SEQ_LEN)) ? LW'(C_MAX_SEQ_LEN) : cfg_len;
  assign cfg_err_d    = (cfg_wr_en && (busy_q || !cfg_idx_ok_d)) || (cfg_len_wr_en && busy_q);
  assign repeat_d     = loop_q && !stop_q && !stop_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_err_q <= 1'b0;
      for (int p = 0; p < C_NUM_PHASES; p++) begin
        len_q[p] <= '0;
        for (int e = 0; e < C_MAX_SEQ_LEN; e++) begin
          tbl_q[p][e] <= '0;
        end
      end
    end else begin
      cfg_err_q <= cfg_err_d;
      if (cfg_wr_en && !busy_q && cfg_idx_ok_d) begin
        tbl_q[cfg_phase][cfg_idx] <= cfg_data;
      end
      if (cfg_len_wr_en && !busy_q) begin
        len_q[cfg_phase] <= cfg_len_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      phase_q   <= '0;
      idx_q     <= '0;
      run_len_q <= '0;
      loop_q    <= 1'b0;
      stop_q    <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      done_q    <= 1'b0;
      addr_q    <= '0;
    end else begin
      done_q <= 1'b0;
      if (busy_q && stop_req) begin
        stop_q <= 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          if (start) begin
            phase_q   <= phase_d;
            run_len_q <= start_len_d;
            idx_q     <= '0;
            stop_q    <= 1'b0;
            loop_q    <= loop_req && (start_len_d != '0);
            if (start_len_d == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_RUN;
              busy_q  <= 1'b1;
              valid_q <= 1'b1;
              addr_q  <= tbl_q[phase_d][0];
              last_q  <= (start_len_d == LW'(1));
            end
          end
        end
        S_RUN: begin
          if (valid_q && wht_data_rdy) begin
            if (last_q) begin
              state_q <= S_DONE;
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              done_q  <= 1'b1;
              busy_q  <= repeat_d;
            end else begin
              idx_q  <= idx_d;
              addr_q <= tbl_q[phase_q][idx_d];
              last_q <= ((LW'(idx_q) + LW'(2)) == run_len_q);
            end
          end
        end
        S_DONE: begin
          // busy still high here only when another pass is due.
          if (busy_q) begin
            state_q <= S_RUN;
            idx_q   <= '0;
            valid_q <= 1'b1;
            addr_q  <= tbl_q[phase_q][0];
            last_q  <= (run_len_q == LW'(1));
          end else begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cfg_err        = cfg_err_q;
  assign busy           = busy_q;
  assign wht_data_valid = valid_q;
  assign wht_data_addr  = addr_q;
  assign wht_data_last  = last_q;
  assign seq_done       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_cnn_layer_accel_wht_seq_gen.sv
`default_nettype none
// Bench for cnn_layer_accel_wht_seq_gen: scoreboard of expected beats plus
// per-scenario timing checks.
module tb_cnn_layer_accel_wht_seq_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_wr_en = 1'b0, cfg_len_wr_en = 1'b0;
  logic [1:0] cfg_phase = '0;
  logic [2:0] cfg_idx = '0;
  logic [3:0] cfg_data = '0;
  logic [2:0] cfg_len = '0;
  logic       cfg_err;
  logic       start = 1'b0;
  logic [1:0] gray_code = '0;
  logic       loop = 1'b0, stop = 1'b0;
  logic       busy, wht_data_valid, wht_data_last, seq_done;
  logic       wht_data_rdy = 1'b1;
  logic [3:0] wht_data_addr;

  cnn_layer_accel_wht_seq_gen dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_wr_en(cfg_wr_en), .cfg_len_wr_en(cfg_len_wr_en), .cfg_phase(cfg_phase),
    .cfg_idx(cfg_idx), .cfg_data(cfg_data), .cfg_len(cfg_len), .cfg_err(cfg_err),
    .start(start), .gray_code(gray_code), .loop(loop), .stop(stop), .busy(busy),
    .wht_data_valid(wht_data_valid), .wht_data_rdy(wht_data_rdy),
    .wht_data_addr(wht_data_addr), .wht_data_last(wht_data_last), .seq_done(seq_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] addr;
    logic       last;
  } beat_t;

  beat_t exp_q[$];
  int    n_checks = 0;
  int    n_errs = 0;
  int    done_cnt = 0;

  // Scoreboard monitor: pops one expected beat per accepted beat and checks
  // that a stalled beat stays unchanged.
  initial begin : monitor
    beat_t      e;
    logic       prev_hold;
    logic [3:0] prev_addr;
    logic       prev_last;
    prev_hold = 1'b0;
    prev_addr = '0;
    prev_last = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_hold = 1'b0;
      end else begin
        if (prev_hold) begin
          n_checks++;
          if (wht_data_valid !== 1'b1 || wht_data_addr !== prev_addr || wht_data_last !== prev_last) begin
            n_errs++;
            $display("FAIL hold: valid=%b addr=%0d last=%b, required valid=1 addr=%0d last=%b",
                     wht_data_valid, wht_data_addr, wht_data_last, prev_addr, prev_last);
          end
        end
        if (wht_data_valid && wht_data_rdy) begin
          n_checks++;
          if (exp_q.size() == 0) begin
            n_errs++;
            $display("FAIL beat: unexpected addr=%0d last=%b, required no beat", wht_data_addr, wht_data_last);
          end else begin
            e = exp_q.pop_front();
            if (wht_data_addr !== e.addr || wht_data_last !== e.last) begin
              n_errs++;
              $display("FAIL beat: addr=%0d last=%b, required addr=%0d last=%b",
                       wht_data_addr, wht_data_last, e.addr, e.last);
            end
          end
        end
        if (seq_done === 1'b1) done_cnt++;
        prev_hold = wht_data_valid && !wht_data_rdy;
        prev_addr = wht_data_addr;
        prev_last = wht_data_last;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_wr(input int ph, input int idx, input int d);
    cfg_phase = 2'(ph); cfg_idx = 3'(idx); cfg_data = 4'(d); cfg_wr_en = 1'b1;
    tick();
    cfg_wr_en = 1'b0;
  endtask

  task automatic cfg_ln(input int ph, input int len);
    cfg_phase = 2'(ph); cfg_len = 3'(len); cfg_len_wr_en = 1'b1;
    tick();
    cfg_len_wr_en = 1'b0;
  endtask

  task automatic exp_push(input int a, input bit l);
    beat_t b;
    b.addr = 4'(a);
    b.last = l;
    exp_q.push_back(b);
  endtask

  // Pulses start; returns the cycle offset (from start) of seq_done, or -1.
  task automatic start_seq(input logic [1:0] g, input bit bp, output int k, output logic busy_at);
    k = -1;
    busy_at = 1'bx;
    gray_code = g;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      if (bp) wht_data_rdy = (c % 3 == 1);
      @(negedge clk);
      if (seq_done === 1'b1) begin
        k = c;
        busy_at = busy;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    wht_data_rdy = 1'b1;
  endtask

  task automatic test_reset();
    repeat (3) tick();
    @(negedge clk);
    n_checks++;
    if ({wht_data_valid, wht_data_last, busy, seq_done, cfg_err} !== 5'b0) begin
      n_errs++;
      $display("FAIL reset_ctrl: valid/last/busy/done/err=%b, required 00000",
               {wht_data_valid, wht_data_last, busy, seq_done, cfg_err});
    end
    n_checks++;
    if (wht_data_addr !== 4'd0) begin
      n_errs++;
      $display("FAIL reset_addr: addr=%0d, required 0", wht_data_addr);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int k; logic b;
    int s[5];
    s = '{1, 3, 4, 5, 6};
    for (int i = 0; i < 5; i++) cfg_wr(0, i, s[i]);
    cfg_ln(0, 5);
    for (int i = 0; i < 5; i++) exp_push(s[i], i == 4);
    start_seq(2'b00, 1'b0, k, b);
    n_checks++;
    if (k !== 6 || b !== 1'b0) begin
      n_errs++;
      $display("FAIL basic_done: done at T+%0d busy=%b, required T+6 busy=0", k, b);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errs++;
      $display("FAIL basic_drain: %0d beats missing, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_gray();
    int k; logic b;
    int s2[5];
    int s3[3];
    s2 = '{4, 5, 6, 2, 3};
    s3 = '{9, 10, 11};
    for (int i = 0; i < 5; i++) cfg_wr(2, i, s2[i]);
    cfg_ln(2, 5);
    for (int i = 0; i < 3; i++) cfg_wr(3, i, s3[i]);
    cfg_ln(3, 3);
    for (int i = 0; i < 5; i++) exp_push(s2[i], i == 4);
    start_seq(2'b11, 1'b0, k, b);
    n_checks++;
    if (k !== 6 || exp_q.size() != 0) begin
      n_errs++;
      $display("FAIL gray11: done T+%0d left=%0d, required T+6 left=0", k, exp_q.size());
      exp_q.delete();
    end
    for (int i = 0; i < 3; i++) exp_push(s3[i], i == 2);
    start_seq(2'b10, 1'b0, k, b);
    n_checks++;
    if (k !== 4 || exp_q.size() != 0) begin
      n_errs++;
      $display("FAIL gray10: done T+%0d left=%0d, required T+4 left=0", k, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_backpressure();
    int k; logic b;
    int s[5];
    s = '{1, 3, 4, 5, 6};
    for (int i = 0; i < 5; i++) exp_push(s[i], i == 4);
    start_seq(2'b00, 1'b1, k, b);
    n_checks++;
    if (k !== 14 || exp_q.size() != 0) begin
      n_errs++;
      $display("FAIL backpressure: done T+%0d left=%0d, required T+14 left=0", k, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_len0();
    int k; logic b;
    cfg_ln(1, 0);
    start_seq(2'b01, 1'b0, k, b);
    n_checks++;
    if (k !== 1) begin
      n_errs++;
      $display("FAIL len0: done at T+%0d, required T+1", k);
    end
  endtask

  task automatic test_clamp();
    int k; logic b;
    int s[5];
    s = '{9, 10, 11, 12, 13};
    cfg_wr(3, 3, 12);
    cfg_wr(3, 4, 13);
    cfg_ln(3, 7);
    for (int i = 0; i < 5; i++) exp_push(s[i], i == 4);
    start_seq(2'b10, 1'b0, k, b);
    n_checks++;
    if (k !== 6 || exp_q.size() != 0) begin
      n_errs++;
      $display("FAIL clamp: done T+%0d left=%0d, required T+6 left=0", k, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_cfg_err();
    int k; logic b;
    int s[5];
    s = '{1, 3, 4, 5, 6};
    cfg_wr(0, 5, 15);
    @(negedge clk);
    n_checks++;
    if (cfg_err !== 1'b1) begin
      n_errs++;
      $display("FAIL err_idx: cfg_err=%b, required 1", cfg_err);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (cfg_err !== 1'b0) begin
      n_errs++;
      $display("FAIL err_pulse: cfg_err=%b, required 0", cfg_err);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) exp_push(s[i], i == 4);
    gray_code = 2'b00;
    start = 1'b1;
    tick();
    start = 1'b0;
    cfg_phase = 2'd0; cfg_idx = 3'd0; cfg_data = 4'd15; cfg_wr_en = 1'b1;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) begin
      n_errs++;
      $display("FAIL busy_t1: busy=%b, required 1", busy);
    end
    @(posedge clk); #1;
    cfg_wr_en = 1'b0;
    @(negedge clk);
    n_checks++;
    if (cfg_err !== 1'b1) begin
      n_errs++;
      $display("FAIL err_busy: cfg_err=%b, required 1", cfg_err);
    end
    for (int c = 0; c < 50 && busy; c++) tick();
    tick();
    n_checks++;
    if (busy !== 1'b0 || exp_q.size() != 0) begin
      n_errs++;
      $display("FAIL err_run: busy=%b left=%0d, required busy=0 left=0", busy, exp_q.size());
      exp_q.delete();
    end
    for (int i = 0; i < 5; i++) exp_push(s[i], i == 4);
    start_seq(2'b00, 1'b0, k, b);
    n_checks++;
    if (k !== 6 || exp_q.size() != 0) begin
      n_errs++;
      $display("FAIL err_table: done T+%0d left=%0d, required T+6 left=0", k, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_loop();
    int k; logic b;
    cfg_wr(1, 0, 7);
    cfg_wr(1, 1, 8);
    cfg_ln(1, 2);
`ifdef CNN_LAYER_ACCEL_WHT_SEQ_LOOP_EN
    begin
      int  d0;
      bit  found;
      d0 = done_cnt;
      found = 1'b0;
      for (int p = 0; p < 2; p++) begin
        exp_push(7, 1'b0);
        exp_push(8, 1'b1);
      end
      gray_code = 2'b01; loop = 1'b1; start = 1'b1;
      tick();
      start = 1'b0; loop = 1'b0;
      for (int c = 0; c < 50; c++) begin
        @(negedge clk);
        if (seq_done === 1'b1) begin found = 1'b1; b = busy; break; end
        @(posedge clk); #1;
      end
      @(posedge clk); #1;
      n_checks++;
      if (!found || b !== 1'b1) begin
        n_errs++;
        $display("FAIL loop_pass1: done=%b busy=%b, required done=1 busy=1", found, b);
      end
      for (int c = 0; c < 50; c++) begin
        @(negedge clk);
        if (wht_data_valid === 1'b1) break;
        @(posedge clk); #1;
      end
      @(posedge clk); #1;
      stop = 1'b1;
      tick();
      stop = 1'b0;
      @(negedge clk);
      n_checks++;
      if (seq_done !== 1'b1 || busy !== 1'b0) begin
        n_errs++;
        $display("FAIL loop_stop: done=%b busy=%b, required done=1 busy=0", seq_done, busy);
      end
      repeat (4) tick();
      n_checks++;
      if (done_cnt != d0 + 2 || exp_q.size() != 0 || wht_data_valid !== 1'b0) begin
        n_errs++;
        $display("FAIL loop_end: passes=%0d left=%0d valid=%b, required 2 0 0",
                 done_cnt - d0, exp_q.size(), wht_data_valid);
        exp_q.delete();
      end
    end
`else
    exp_push(7, 1'b0);
    exp_push(8, 1'b1);
    loop = 1'b1;
    start_seq(2'b01, 1'b0, k, b);
    loop = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (k !== 3 || b !== 1'b0 || exp_q.size() != 0 || busy !== 1'b0) begin
      n_errs++;
      $display("FAIL loop_off: done T+%0d busy=%b left=%0d, required T+3 busy=0 left=0",
               k, b, exp_q.size());
      exp_q.delete();
    end
`endif
  endtask

  task automatic test_async_reset();
    int k; logic b;
    int s[5];
    s = '{1, 3, 4, 5, 6};
    for (int i = 0; i < 5; i++) exp_push(s[i], i == 4);
    gray_code = 2'b00;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (wht_data_valid !== 1'b0 || busy !== 1'b0 || wht_data_addr !== 4'd0) begin
      n_errs++;
      $display("FAIL async_rst: valid=%b busy=%b addr=%0d, required 0 0 0",
               wht_data_valid, busy, wht_data_addr);
    end
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
    cfg_ln(0, 2);
    exp_push(0, 1'b0);
    exp_push(0, 1'b1);
    start_seq(2'b00, 1'b0, k, b);
    n_checks++;
    if (k !== 3 || exp_q.size() != 0) begin
      n_errs++;
      $display("FAIL rst_table: done T+%0d left=%0d, required T+3 left=0", k, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gray();
    test_backpressure();
    test_len0();
    test_clamp();
    test_cfg_err();
    test_loop();
    test_async_reset();
    repeat (2) tick();
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
